// File: rtl/test_access_ctrl_if.sv
// Handshake and data bundle between a test controller and test_access_ctrl.
// The controller drives through the master modport; the capture block sits on the slave modport.
interface test_access_ctrl_if #(
  parameter int NCH = 8,
  parameter int W   = 4
);

  logic             inCfgLoad;
  logic             inCfgData;
  logic             inCfgApply;
  logic [NCH*W-1:0] inObsData;
  logic             inTrigger;
  logic             inReadEnable;

  logic [W-1:0]     outObs;
  logic [W-1:0]     outData;
  logic             outEmpty;
  logic             outFull;
  logic             outArmed;
  logic             outDone;

  modport master (
    output inCfgLoad, inCfgData, inCfgApply, inObsData, inTrigger, inReadEnable,
    input  outObs, outData, outEmpty, outFull, outArmed, outDone
  );

  modport slave (
    input  inCfgLoad, inCfgData, inCfgApply, inObsData, inTrigger, inReadEnable,
    output outObs, outData, outEmpty, outFull, outArmed, outDone
  );

endinterface

// File: rtl/test_access_ctrl.sv
// Observation mux plus trigger-driven capture buffer (single-shot or pre-trigger ring).
// Defining TAC_DECIM_EN adds a 4-bit decimation field to the serial configuration word.
module test_access_ctrl #(
  parameter int NCH   = 8,
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic              inClock,
  input  logic              inReset,
  test_access_ctrl_if.slave tac
);

  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef TAC_DECIM_EN
  localparam int CFGW = SELW + 6;
`else
  localparam int CFGW = SELW + 2;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0]    MODE_SINGLE = 2'b01;
  localparam logic [1:0]    MODE_RING   = 2'b10;
  localparam logic [CW-1:0] CNT_FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_HALF    = CW'(DEPTH / 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_e;

  logic [CFGW-1:0] shadow_q;
  logic [CFGW-1:0] cfg_q;
  state_e          state_q;
  logic            armed_q;
  logic            done_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   cap_cnt_q;
  logic [W-1:0]    obs_q;
  logic [W-1:0]    data_q;
  logic [W-1:0]    mem [DEPTH];

  logic [SELW-1:0] cfg_sel;
  logic [1:0]      cfg_mode;
  logic [1:0]      new_mode;
  logic [W-1:0]    sample;
  logic [CW-1:0]   cap_target;
  logic            apply;
  logic            trig_fire;
  logic            dec_tick;
  logic            wr_en;
  logic            pop_en;
  logic            cap_last;

  assign apply    = tac.inCfgApply;
  assign cfg_sel  = cfg_q[SELW-1:0];
  assign cfg_mode = cfg_q[SELW+1:SELW];
  assign new_mode = shadow_q[SELW+1:SELW];

`ifdef TAC_DECIM_EN
  logic [3:0] cfg_dec;
  logic [3:0] dec_cnt_q;

  assign cfg_dec  = cfg_q[SELW+5:SELW+2];
  assign dec_tick = (dec_cnt_q == 4'd0);
`else
  assign dec_tick = 1'b1;
`endif

  // Out-of-range selects fall through to zero because no channel matches.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    sample = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(cfg_sel) == k) sample = tac.inObsData[k*W +: W];
    end
  end

  // Apply has priority: a trigger, write or pop in the apply cycle is dropped.
  assign trig_fire  = !apply && (state_q == S_ARMED) && tac.inTrigger;
  assign wr_en      = !apply &&
                      (((state_q == S_ARMED) && (trig_fire || ((cfg_mode == MODE_RING) && dec_tick))) ||
                       ((state_q == S_CAPTURE) && dec_tick));
  assign pop_en     = !apply && (state_q == S_DONE) && (count_q != '0) && tac.inReadEnable;
  assign cap_target = (cfg_mode == MODE_SINGLE) ? CNT_FULL : CNT_HALF;
  assign cap_last   = ((cap_cnt_q + CW'(1)) == cap_target);

  // NOTE: the buffer array is not reset; pointers and count define what is valid.
  always_ff @(posedge inClock) begin
    if (wr_en) mem[wr_ptr_q] <= sample;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      shadow_q  <= '0;
      cfg_q     <= '0;
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cap_cnt_q <= '0;
      obs_q     <= '0;
      data_q    <= '0;
`ifdef TAC_DECIM_EN
      dec_cnt_q <= '0;
`endif
    end else begin
      obs_q <= sample;

      if (tac.inCfgLoad) shadow_q <= {tac.inCfgData, shadow_q[CFGW-1:1]};

      if (apply) begin
        cfg_q     <= shadow_q;
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        cap_cnt_q <= '0;
        done_q    <= 1'b0;
`ifdef TAC_DECIM_EN
        dec_cnt_q <= '0;
`endif
        if ((new_mode == MODE_SINGLE) || (new_mode == MODE_RING)) begin
          state_q <= S_ARMED;
          armed_q <= 1'b1;
        end else begin
          state_q <= S_IDLE;
          armed_q <= 1'b0;
        end
      end else begin
        // A write into a full ring drops the oldest entry by advancing the read side.
        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
          if (count_q == CNT_FULL) rd_ptr_q <= rd_ptr_q + AW'(1);
          else                     count_q  <= count_q + CW'(1);
        end else if (pop_en) begin
          data_q   <= mem[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + AW'(1);
          count_q  <= count_q - CW'(1);
        end

`ifdef TAC_DECIM_EN
        // The trigger restarts the decimation phase so its sample anchors the grid.
        if ((state_q == S_ARMED) || (state_q == S_CAPTURE)) begin
          dec_cnt_q <= (trig_fire || dec_tick) ? cfg_dec : dec_cnt_q - 4'd1;
        end
`endif

        case (state_q)
          S_ARMED: begin
            if (trig_fire) begin
              state_q   <= S_CAPTURE;
              cap_cnt_q <= CW'(1);
            end
          end
          S_CAPTURE: begin
            if (wr_en) begin
              cap_cnt_q <= cap_cnt_q + CW'(1);
              if (cap_last) begin
                state_q <= S_DONE;
                armed_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tac.outObs   = obs_q;
  assign tac.outData  = data_q;
  assign tac.outEmpty = (count_q == '0);
  assign tac.outFull  = (count_q == CNT_FULL);
  assign tac.outArmed = armed_q;
  assign tac.outDone  = done_q;

endmodule

// File: tb/tb_test_access_ctrl.sv
// Directed bench for test_access_ctrl: configuration, live view, single-shot, ring, apply and reset.
// With TAC_DECIM_EN defined it also checks the decimated single-shot capture.
module tb_test_access_ctrl;

  localparam int NCH = 8;
`ifdef TAC_DECIM_EN
  localparam int CFGW = 9;
`else
  localparam int CFGW = 5;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  test_access_ctrl_if #(.NCH(8), .W(4)) tac ();
  test_access_ctrl_if #(.NCH(6), .W(4)) tac2 ();

  test_access_ctrl #(.NCH(8), .W(4), .DEPTH(16)) dut (
    .inClock (clk),
    .inReset (rst_n),
    .tac     (tac)
  );

  test_access_ctrl #(.NCH(6), .W(4), .DEPTH(16)) dut_n6 (
    .inClock (clk),
    .inReset (rst_n),
    .tac     (tac2)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  chv [NCH];
  int          cnt_ch   = -1;
  logic [7:0]  ctr      = 8'd0;
  logic [3:0]  v0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < NCH; k++) tac.inObsData[k*4 +: 4] = chv[k];
    for (int k = 0; k < 6; k++)   tac2.inObsData[k*4 +: 4] = chv[k];
  endtask

  task automatic tick();
    @(negedge clk);
    ctr = ctr + 8'd1;
    if (cnt_ch >= 0) chv[cnt_ch] = ctr[3:0];
    pack();
  endtask

  task automatic set_ch(input int k, input logic [3:0] v);
    chv[k] = v;
    pack();
  endtask

  task automatic set_counter(input int k);
    cnt_ch = k;
    chv[k] = ctr[3:0];
    pack();
  endtask

  function automatic logic [8:0] mk_cfg(input logic [3:0] dec, input logic [1:0] mode,
                                        input logic [2:0] sel);
    return {dec, mode, sel};
  endfunction

  task automatic cfg_write(input bit second, input logic [8:0] cfg);
    for (int i = 0; i < CFGW; i++) begin
      if (second) begin
        tac2.inCfgLoad = 1'b1;
        tac2.inCfgData = cfg[i];
      end else begin
        tac.inCfgLoad = 1'b1;
        tac.inCfgData = cfg[i];
      end
      tick();
    end
    tac.inCfgLoad  = 1'b0;
    tac2.inCfgLoad = 1'b0;
    if (second) tac2.inCfgApply = 1'b1;
    else        tac.inCfgApply  = 1'b1;
    tick();
    tac.inCfgApply  = 1'b0;
    tac2.inCfgApply = 1'b0;
  endtask

  task automatic align_to(input logic [3:0] v);
    for (int i = 0; i < 20 && ctr[3:0] != v; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) chv[k] = 4'(k + 8);
    pack();
    tac.inCfgLoad  = 1'b0; tac.inCfgData  = 1'b0; tac.inCfgApply  = 1'b0;
    tac.inTrigger  = 1'b0; tac.inReadEnable  = 1'b0;
    tac2.inCfgLoad = 1'b0; tac2.inCfgData = 1'b0; tac2.inCfgApply = 1'b0;
    tac2.inTrigger = 1'b0; tac2.inReadEnable = 1'b0;

    // Reset state
    #2;
    check("rst_obs",   32'(tac.outObs),   32'h0);
    check("rst_data",  32'(tac.outData),  32'h0);
    check("rst_empty", 32'(tac.outEmpty), 32'h1);
    check("rst_full",  32'(tac.outFull),  32'h0);
    check("rst_armed", 32'(tac.outArmed), 32'h0);
    check("rst_done",  32'(tac.outDone),  32'h0);
    #1 rst_n = 1'b1;
    tick();

    // Single-shot on channel 3, trigger at value 2
    cfg_write(1'b0, mk_cfg(4'd0, 2'b01, 3'd3));
    check("ss_armed", 32'(tac.outArmed), 32'h1);
    check("ss_empty", 32'(tac.outEmpty), 32'h1);
    set_counter(3);
    align_to(4'h2);
    tac.inTrigger = 1'b1;
    tick();
    tac.inTrigger = 1'b0;
    check("ss_cap_armed", 32'(tac.outArmed), 32'h1);
    check("ss_cap_empty", 32'(tac.outEmpty), 32'h0);
    repeat (14) tick();
    check("ss_not_done_yet", 32'(tac.outDone), 32'h0);
    tick();
    check("ss_done",      32'(tac.outDone),  32'h1);
    check("ss_full",      32'(tac.outFull),  32'h1);
    check("ss_disarmed",  32'(tac.outArmed), 32'h0);
    tac.inReadEnable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("ss_pop_data",  32'(tac.outData),  32'((2 + i) % 16));
      check("ss_pop_empty", 32'(tac.outEmpty), 32'(i == 15));
    end
    tick();
    check("ss_extra_pop_data", 32'(tac.outData), 32'h1);
    check("ss_done_after_drain", 32'(tac.outDone), 32'h1);
    tac.inReadEnable = 1'b0;

    // Live view latency and out-of-range select
    cfg_write(1'b0, mk_cfg(4'd0, 2'b00, 3'd5));
    cnt_ch = -1;
    check("off_armed", 32'(tac.outArmed), 32'h0);
    check("off_done",  32'(tac.outDone),  32'h0);
    set_ch(5, 4'hA);
    tick();
    check("obs_a", 32'(tac.outObs), 32'hA);
    set_ch(5, 4'h3);
    check("obs_a_hold", 32'(tac.outObs), 32'hA);
    tick();
    check("obs_3", 32'(tac.outObs), 32'h3);
    cfg_write(1'b1, mk_cfg(4'd0, 2'b00, 3'd5));
    tick();
    check("n6_obs_sel5", 32'(tac2.outObs), 32'h3);
    cfg_write(1'b1, mk_cfg(4'd0, 2'b00, 3'd7));
    tick();
    check("n6_obs_sel7", 32'(tac2.outObs), 32'h0);

    // Pre-trigger ring with a full history, trigger at count 40
    cfg_write(1'b0, mk_cfg(4'd0, 2'b10, 3'd0));
    set_counter(0);
    for (int n = 0; n < 600 && (n < 16 || ctr != 8'd40); n++) tick();
    check("ring_full_pre", 32'(tac.outFull),  32'h1);
    check("ring_armed",    32'(tac.outArmed), 32'h1);
    tac.inTrigger = 1'b1;
    tick();
    tac.inTrigger = 1'b0;
    repeat (6) tick();
    check("ring_not_done_yet", 32'(tac.outDone), 32'h0);
    tick();
    check("ring_done", 32'(tac.outDone), 32'h1);
    tac.inReadEnable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("ring_pop_data",  32'(tac.outData),  32'(i));
      check("ring_pop_empty", 32'(tac.outEmpty), 32'(i == 15));
    end
    tac.inReadEnable = 1'b0;

    // Ring with only two pre-trigger samples: 10 entries total
    cfg_write(1'b0, mk_cfg(4'd0, 2'b10, 3'd0));
    v0 = chv[0];
    tick();
    tick();
    tac.inTrigger = 1'b1;
    tick();
    tac.inTrigger = 1'b0;
    repeat (7) tick();
    check("short_done", 32'(tac.outDone), 32'h1);
    check("short_full", 32'(tac.outFull), 32'h0);
    tac.inReadEnable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("short_pop_data",  32'(tac.outData),  32'(4'(v0 + 4'(i))));
      check("short_pop_empty", 32'(tac.outEmpty), 32'(i == 9));
    end
    tac.inReadEnable = 1'b0;

    // Apply during capture flushes and re-arms; trigger in the apply cycle is dropped
    cfg_write(1'b0, mk_cfg(4'd0, 2'b01, 3'd3));
    set_counter(3);
    tac.inTrigger = 1'b1;
    tick();
    tac.inTrigger = 1'b0;
    tick();
    tick();
    check("reapply_pre_nonempty", 32'(tac.outEmpty), 32'h0);
    tac.inCfgApply = 1'b1;
    tac.inTrigger  = 1'b1;
    tick();
    tac.inCfgApply = 1'b0;
    tac.inTrigger  = 1'b0;
    check("reapply_empty", 32'(tac.outEmpty), 32'h1);
    check("reapply_armed", 32'(tac.outArmed), 32'h1);
    check("reapply_done",  32'(tac.outDone),  32'h0);
    repeat (3) tick();
    check("reapply_no_capture", 32'(tac.outEmpty), 32'h1);

    // Asynchronous reset in the middle of a capture
    tac.inTrigger = 1'b1;
    tick();
    tac.inTrigger = 1'b0;
    tick();
    tick();
    check("pre_rst_empty", 32'(tac.outEmpty), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_obs",   32'(tac.outObs),   32'h0);
    check("arst_data",  32'(tac.outData),  32'h0);
    check("arst_empty", 32'(tac.outEmpty), 32'h1);
    check("arst_full",  32'(tac.outFull),  32'h0);
    check("arst_armed", 32'(tac.outArmed), 32'h0);
    check("arst_done",  32'(tac.outDone),  32'h0);
    tick();
    rst_n = 1'b1;
    tac.inReadEnable = 1'b1;
    tac.inTrigger    = 1'b1;
    repeat (3) tick();
    check("post_rst_empty", 32'(tac.outEmpty), 32'h1);
    check("post_rst_data",  32'(tac.outData),  32'h0);
    check("post_rst_armed", 32'(tac.outArmed), 32'h0);
    check("post_rst_done",  32'(tac.outDone),  32'h0);
    tac.inReadEnable = 1'b0;
    tac.inTrigger    = 1'b0;

`ifdef TAC_DECIM_EN
    // Decimation by 3, single-shot, trigger at counter value 0
    cfg_write(1'b0, mk_cfg(4'd2, 2'b01, 3'd0));
    set_counter(0);
    align_to(4'h0);
    tac.inTrigger = 1'b1;
    tick();
    tac.inTrigger = 1'b0;
    for (int i = 0; i < 60 && !tac.outDone; i++) tick();
    check("dec_done", 32'(tac.outDone), 32'h1);
    tac.inReadEnable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("dec_pop_data", 32'(tac.outData), 32'((3 * i) % 16));
    end
    tac.inReadEnable = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/test_access_ctrl.md
TEST_ACCESS_CTRL -- requirements
Module: test_access_ctrl

Interface
REQ-001 Parameter NCH, default 8: number of observation channels.
REQ-002 Parameter W, default 4: channel width in bits.
REQ-003 Parameter DEPTH, default 16: capture buffer entries; power of two, >=4.
REQ-004 Derived constants: SELW = clog2(NCH); CFGW = SELW+2 (SELW+6 with TAC_DECIM_EN).
REQ-005 inClock  in  1  single clock; all state updates on its rising edge.
REQ-006 inReset  in  1  asynchronous, active-low reset.
REQ-007 inCfgLoad  in  1  shift enable for the serial configuration shadow register.
REQ-008 inCfgData  in  1  serial configuration bit, LSB first.
REQ-009 inCfgApply  in  1  commits shadow to active configuration.
REQ-010 inObsData  in  NCH*W  observation bus; channel k at bits [k*W +: W].
REQ-011 inTrigger  in  1  capture trigger, level-sampled.
REQ-012 inReadEnable  in  1  capture buffer pop request.
REQ-013 outObs  out  W  registered live view of the selected channel.
REQ-014 outData  out  W  capture buffer read data.
REQ-015 outEmpty / outFull  out  1 each  capture buffer status.
REQ-016 outArmed / outDone  out  1 each  FSM status: ARMED or CAPTURE / DONE.

Function
REQ-017 Active config fields: sel=[SELW-1:0], mode=[SELW+1:SELW]; 00 off, 01 single-shot, 10 pre-trigger ring, 11 treated as off.
REQ-018 inCfgLoad=1 SHALL shift: shadow <= {inCfgData, shadow[CFGW-1:1]}.
REQ-019 inCfgApply=1 SHALL copy the pre-shift shadow to active, flush the buffer, and enter ARMED (modes 01/10) or IDLE (off); Load and Apply in the same cycle both take effect.
REQ-020 outObs SHALL equal the channel selected in the previous cycle (1-cycle latency); sel>=NCH yields zero.
REQ-021 FSM states: IDLE, ARMED, CAPTURE, DONE.
REQ-022 Mode 01: in ARMED, trigger high writes the current sample as entry 0 and enters CAPTURE; one sample per cycle follows; after the DEPTH-th write enter DONE.
REQ-023 Mode 10: ARMED writes every cycle into a ring; when full, the oldest entry is overwritten and the read pointer advances; trigger writes the current sample and enters CAPTURE; DONE after DEPTH/2 writes including the trigger sample.
REQ-024 Mode 10 with fewer than DEPTH/2 pre-trigger samples: the buffer holds only the samples written.
REQ-025 Pops are honoured only in DONE and when not empty; outData is valid the cycle after the pop; all other pops are ignored and leave state unchanged.
REQ-026 DONE persists until Apply or reset, including after the buffer drains.
REQ-027 Trigger in IDLE, CAPTURE or DONE is ignored.
REQ-028 outFull = count==DEPTH; outEmpty = count==0; count width clog2(DEPTH)+1.

Reset
REQ-029 inReset low SHALL immediately clear: shadow, active config (sel 0, mode off), FSM to IDLE, pointers and count, outObs=0, outData=0, outEmpty=1, outFull=0, outArmed=0, outDone=0.
REQ-030 Reset mid-capture discards all captured data; there is no partial-buffer recovery.

Configuration
REQ-031 Macro TAC_DECIM_EN defined: config gains field dec=[SELW+5:SELW+2]; ARMED/CAPTURE writes occur every (dec+1)-th cycle, counted from the trigger cycle (the trigger sample is always written); CFGW=SELW+6.
REQ-032 Macro TAC_DECIM_EN undefined: writes occur every cycle; no dec field; CFGW=SELW+2.

Verification (NCH=8, W=4, DEPTH=16, no macro unless stated)
REQ-033 Shift LSB-first 1,1,0,1,0 (sel=3, mode=01), apply; channel 3 = free counter; trigger at value 2 -> outDone 16 cycles later; 16 pops return 2..F,0,1; outEmpty after the 16th pop.
REQ-034 sel=5, ch5=4'hA then 4'h3 -> outObs 4'hA then 4'h3, each one cycle later; NCH=6 with sel=7 -> outObs=0.
REQ-035 mode=10, 8-bit counter on ch0 (low nibble observed), trigger at count 40 after >=16 pre-samples -> 16 entries; pops return 0..F (counts 32..47 low nibble).
REQ-036 Reset asserted in CAPTURE mid-cycle -> outputs at reset values asynchronously; FSM IDLE; pops ignored afterward.
REQ-037 Apply during CAPTURE with mode=01 -> buffer flushed, outEmpty=1, ARMED; trigger on the same cycle as Apply is ignored.
REQ-038 TAC_DECIM_EN, dec=2, mode 01, counter ch0, trigger at 0 -> pops return 0,3,6,9,C,F,2,...
